ibuf_flow_ctrl: RTL and testbench

//  Flow/sequencing controller for the 32-entry fetch->decode instruction buffer (8 in / 4 out).

---
 rtl/ace_ibuf_pkg.sv | 31 +++
 rtl/ibuf_credit_ctr.sv | 42 ++++
 rtl/ibuf_flow_ctrl.sv | 93 +++++++++
 tb/tb_ibuf_flow_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_ibuf_pkg.sv
// rtl/ace_ibuf_pkg.sv - shared constants, state encoding and pop helper for the instruction buffer controller
package ace_ibuf_pkg;

  localparam int IBUF_DEPTH   = 32;
  localparam int IBUF_IN_W    = 8;
  localparam int IBUF_OUT_W   = 4;
  localparam int IBUF_MAX_OUT = 2;

  localparam int OCC_W    = 6;
  localparam int WR_CNT_W = 4;
  localparam int RD_CNT_W = 3;
  localparam int OUTST_W  = 2;
  localparam int FREE_W   = 7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    REFILL = 2'd2
  } ibuf_state_e;

  // Pop count is the smallest of what is buffered, what decode takes, and the port width.
  function automatic logic [RD_CNT_W-1:0] pop_min(input logic [OCC_W-1:0]    occ,
                                                  input logic [RD_CNT_W-1:0] rdy);
    logic [OCC_W-1:0] m;
    m = OCC_W'(IBUF_OUT_W);
    if (OCC_W'(rdy) < m) m = OCC_W'(rdy);
    if (occ < m) m = occ;
    return RD_CNT_W'(m);
  endfunction

endpackage

// File: rtl/ibuf_credit_ctr.sv
// rtl/ibuf_credit_ctr.sv - outstanding fetch counter and free-credit request throttle
module ibuf_credit_ctr
  import ace_ibuf_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_allow_i,
  input  logic [OCC_W-1:0]   occ_i,
  input  logic               fetch_ack_i,
  input  logic               fetch_rtn_i,
  output logic               fetch_req_o,
  output logic               rtn_valid_o,
  output logic               rtn_err_o,
  output logic [OUTST_W-1:0] outst_nxt_o
);

  logic [OUTST_W-1:0]       outst_q, outst_d;
  logic signed [FREE_W-1:0] free;

  // Every outstanding bundle reserves a full IN_W slots, whatever it finally returns.
  assign free = $signed(FREE_W'(IBUF_DEPTH) - FREE_W'(occ_i)
                        - FREE_W'(outst_q) * FREE_W'(IBUF_IN_W));

  assign fetch_req_o = req_allow_i
                    && (outst_q < OUTST_W'(IBUF_MAX_OUT))
                    && (free >= $signed(FREE_W'(IBUF_IN_W)));

  assign rtn_valid_o = fetch_rtn_i && (outst_q != '0);
  assign rtn_err_o   = fetch_rtn_i && (outst_q == '0);

  assign outst_d     = outst_q + OUTST_W'(fetch_req_o && fetch_ack_i) - OUTST_W'(rtn_valid_o);
  assign outst_nxt_o = outst_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

endmodule

// File: rtl/ibuf_flow_ctrl.sv
// rtl/ibuf_flow_ctrl.sv - occupancy, pop control and flush sequencing for the fetch->decode buffer
module ibuf_flow_ctrl
  import ace_ibuf_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_i,
  output logic                fetch_req_o,
  input  logic                fetch_ack_i,
  input  logic                fetch_rtn_i,
  input  logic [WR_CNT_W-1:0] fetch_rtn_cnt_i,
  output logic                buf_wr_en_o,
  output logic [WR_CNT_W-1:0] buf_wr_cnt_o,
  output logic                buf_flush_o,
  input  logic [RD_CNT_W-1:0] dec_rdy_i,
  output logic [RD_CNT_W-1:0] buf_rd_cnt_o,
  output logic [OCC_W-1:0]    occ_o,
  output logic                stall_o,
  output logic                err_o
);

  ibuf_state_e        state_q, state_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               err_q, err_d;
  logic [OCC_W:0]     occ_sum;
  logic               req_allow;
  logic               rtn_valid;
  logic               rtn_err;
  logic [OUTST_W-1:0] outst_nxt;

  // Holding reset must keep request and flush quiet even though REFILL would otherwise request.
  assign req_allow = reset_n && !flush_i && (state_q != DRAIN);

  ibuf_credit_ctr u_credit (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_allow_i (req_allow),
    .occ_i       (occ_q),
    .fetch_ack_i (fetch_ack_i),
    .fetch_rtn_i (fetch_rtn_i),
    .fetch_req_o (fetch_req_o),
    .rtn_valid_o (rtn_valid),
    .rtn_err_o   (rtn_err),
    .outst_nxt_o (outst_nxt)
  );

  assign buf_flush_o = flush_i && reset_n;
  assign occ_o       = occ_q;
  assign err_o       = err_q;
  assign stall_o     = (state_q != RUN) || (occ_q == '0);

  always_comb begin
    state_d      = state_q;
    err_d        = err_q || rtn_err;
    buf_wr_en_o  = rtn_valid && !flush_i && (state_q != DRAIN);
    buf_wr_cnt_o = buf_wr_en_o ? fetch_rtn_cnt_i : '0;
    buf_rd_cnt_o = ((state_q == RUN) && !flush_i) ? pop_min(occ_q, dec_rdy_i) : '0;

    // Pops use registered occupancy only, so this cycle's write is never bypassed to decode.
    occ_sum = (OCC_W+1)'(occ_q) + (OCC_W+1)'(buf_wr_cnt_o) - (OCC_W+1)'(buf_rd_cnt_o);
    if (occ_sum > (OCC_W+1)'(IBUF_DEPTH)) begin
      err_d = 1'b1;
      occ_d = OCC_W'(IBUF_DEPTH);
    end else begin
      occ_d = occ_sum[OCC_W-1:0];
    end

    case (state_q)
      RUN:     ;
      REFILL:  if (buf_wr_en_o && (buf_wr_cnt_o != '0)) state_d = RUN;
      DRAIN:   if (outst_nxt == '0) state_d = REFILL;
      default: state_d = REFILL;
    endcase

    if (flush_i) begin
      occ_d   = '0;
      state_d = (outst_nxt != '0) ? DRAIN : REFILL;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= REFILL;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ibuf_flow_ctrl.sv
// tb/tb_ibuf_flow_ctrl.sv - self-checking bench for ibuf_flow_ctrl against a cycle-level reference model
module tb_ibuf_flow_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush_i = 1'b0, fetch_ack_i = 1'b0, fetch_rtn_i = 1'b0;
  logic [3:0] fetch_rtn_cnt_i = '0;
  logic [2:0] dec_rdy_i = '0;
  logic       fetch_req_o, buf_wr_en_o, buf_flush_o, stall_o, err_o;
  logic [3:0] buf_wr_cnt_o;
  logic [2:0] buf_rd_cnt_o;
  logic [5:0] occ_o;

  int n_err = 0;
  int n_chk = 0;

  localparam int S_RUN = 0, S_DRAIN = 1, S_REFILL = 2;
  int m_st, m_occ, m_out;
  bit m_err;
  bit e_req, e_wr_en, e_flush, e_stall, c_rv, c_ack, c_flush, c_rtn;
  int e_wr_cnt, e_rd;

  always #5 clock = ~clock;

  ibuf_flow_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush_i         (flush_i),
    .fetch_req_o     (fetch_req_o),
    .fetch_ack_i     (fetch_ack_i),
    .fetch_rtn_i     (fetch_rtn_i),
    .fetch_rtn_cnt_i (fetch_rtn_cnt_i),
    .buf_wr_en_o     (buf_wr_en_o),
    .buf_wr_cnt_o    (buf_wr_cnt_o),
    .buf_flush_o     (buf_flush_o),
    .dec_rdy_i       (dec_rdy_i),
    .buf_rd_cnt_o    (buf_rd_cnt_o),
    .occ_o           (occ_o),
    .stall_o         (stall_o),
    .err_o           (err_o)
  );

  function automatic logic [17:0] exp_vec();
    return {e_req, e_wr_en, 4'(e_wr_cnt), 3'(e_rd), e_flush, 6'(m_occ), e_stall, m_err};
  endfunction

  function automatic logic [17:0] got_vec();
    return {fetch_req_o, buf_wr_en_o, buf_wr_cnt_o, buf_rd_cnt_o, buf_flush_o, occ_o, stall_o, err_o};
  endfunction

  task automatic model_reset();
    m_st = S_REFILL; m_occ = 0; m_out = 0; m_err = 1'b0;
  endtask

  // Apply inputs, predict this cycle's outputs, then stop at the falling edge for sampling.
  task automatic cyc(input bit fl, input bit ack, input bit rtn, input int cnt, input int rdy);
    int free, mn;
    flush_i = fl; fetch_ack_i = ack; fetch_rtn_i = rtn;
    fetch_rtn_cnt_i = 4'(cnt); dec_rdy_i = 3'(rdy);
    free     = 32 - m_occ - 8 * m_out;
    e_req    = !fl && m_st != S_DRAIN && m_out < 2 && free >= 8;
    c_rv     = rtn && m_out > 0;
    e_wr_en  = c_rv && !fl && m_st != S_DRAIN;
    e_wr_cnt = e_wr_en ? cnt : 0;
    mn = m_occ;
    if (rdy < mn) mn = rdy;
    if (4 < mn) mn = 4;
    e_rd    = (m_st == S_RUN && !fl) ? mn : 0;
    e_flush = fl;
    e_stall = m_st != S_RUN || m_occ == 0;
    c_ack = ack; c_flush = fl; c_rtn = rtn;
    @(negedge clock);
  endtask

  task automatic tick();
    int n_out, occ;
    @(posedge clock);
    n_out = m_out + ((e_req && c_ack) ? 1 : 0) - (c_rv ? 1 : 0);
    if (c_rtn && m_out == 0) m_err = 1'b1;
    occ = m_occ + e_wr_cnt - e_rd;
    if (occ > 32) begin m_err = 1'b1; occ = 32; end
    if (c_flush) begin
      occ  = 0;
      m_st = (n_out != 0) ? S_DRAIN : S_REFILL;
    end else if (m_st == S_REFILL && e_wr_en && e_wr_cnt > 0) begin
      m_st = S_RUN;
    end else if (m_st == S_DRAIN && n_out == 0) begin
      m_st = S_REFILL;
    end
    m_occ = occ; m_out = n_out;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush_i = 1'b0; fetch_ack_i = 1'b0; fetch_rtn_i = 1'b0;
    fetch_rtn_cnt_i = '0; dec_rdy_i = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    fetch_ack_i = 1'b1; dec_rdy_i = 3'd4; flush_i = 1'b1;
    @(negedge clock);
    n_chk++;
    if (got_vec() !== 18'h00002) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=%h", got_vec(), 18'h00002);
    end
    flush_i = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    n_chk++;
    if (fetch_req_o !== 1'b1 || stall_o !== 1'b1) begin
      n_err++; $display("FAIL reset_refill_req got=%b%b exp=11", fetch_req_o, stall_o);
    end
    tick();
  endtask

  task automatic test_fill();
    bit sched[0:31];
    int nreq = 0;
    bit rtn;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      rtn = (c >= 2) ? sched[c-2] : 1'b0;
      cyc(0, 1, rtn, 8, 0);
      sched[c] = e_req;
      if (fetch_req_o === 1'b1) nreq++;
      n_chk++;
      if (got_vec() !== exp_vec()) begin
        n_err++; $display("FAIL fill_cycle c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      tick();
    end
    cyc(0, 1, 0, 0, 0);
    n_chk++;
    if (nreq != 4 || occ_o !== 6'd32 || fetch_req_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL fill_final got req=%0d occ=%0d fr=%b err=%b exp req=4 occ=32 fr=0 err=0",
                        nreq, occ_o, fetch_req_o, err_o);
    end
    tick();
  endtask

  task automatic test_drain_pop();
    int exp_rd[4], exp_occ[4];
    bit exp_st[4];
    exp_rd = '{4, 4, 2, 0}; exp_occ = '{10, 6, 2, 0}; exp_st = '{0, 0, 0, 1};
    do_reset();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 0, 1, 8, 0); tick();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 0, 1, 2, 0); tick();
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 4);
      n_chk++;
      if (buf_rd_cnt_o !== 3'(exp_rd[k]) || occ_o !== 6'(exp_occ[k]) || stall_o !== exp_st[k]) begin
        n_err++; $display("FAIL pop_seq k=%0d got rd=%0d occ=%0d st=%b exp rd=%0d occ=%0d st=%b",
                          k, buf_rd_cnt_o, occ_o, stall_o, exp_rd[k], exp_occ[k], exp_st[k]);
      end
      tick();
    end
  endtask

  task automatic test_flush_drain();
    do_reset();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 0, 1, 8, 0); tick();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(1, 1, 0, 0, 0);
    n_chk++;
    if (buf_flush_o !== 1'b1 || fetch_req_o !== 1'b0) begin
      n_err++; $display("FAIL flush_pulse got fl=%b req=%b exp fl=1 req=0", buf_flush_o, fetch_req_o);
    end
    tick();
    cyc(0, 1, 1, 8, 4);
    n_chk++;
    if (occ_o !== 6'd0 || stall_o !== 1'b1 || fetch_req_o !== 1'b0 || buf_wr_en_o !== 1'b0 || buf_rd_cnt_o !== 3'd0) begin
      n_err++; $display("FAIL drain_first got occ=%0d st=%b req=%b wr=%b rd=%0d exp 0 1 0 0 0",
                        occ_o, stall_o, fetch_req_o, buf_wr_en_o, buf_rd_cnt_o);
    end
    tick();
    cyc(0, 1, 1, 8, 4);
    n_chk++;
    if (buf_wr_en_o !== 1'b0 || fetch_req_o !== 1'b0) begin
      n_err++; $display("FAIL drain_second got wr=%b req=%b exp wr=0 req=0", buf_wr_en_o, fetch_req_o);
    end
    tick();
    cyc(0, 1, 0, 0, 4);
    n_chk++;
    if (fetch_req_o !== 1'b1 || occ_o !== 6'd0 || stall_o !== 1'b1) begin
      n_err++; $display("FAIL refill_entry got req=%b occ=%0d st=%b exp req=1 occ=0 st=1",
                        fetch_req_o, occ_o, stall_o);
    end
    tick();
  endtask

  task automatic test_flush_collide();
    do_reset();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(1, 1, 1, 8, 0);
    n_chk++;
    if (buf_wr_en_o !== 1'b0 || fetch_req_o !== 1'b0 || buf_flush_o !== 1'b1) begin
      n_err++; $display("FAIL collide_squash got wr=%b req=%b fl=%b exp wr=0 req=0 fl=1",
                        buf_wr_en_o, fetch_req_o, buf_flush_o);
    end
    tick();
    cyc(0, 1, 0, 0, 0);
    n_chk++;
    if (fetch_req_o !== 1'b1 || err_o !== 1'b0) begin
      n_err++; $display("FAIL collide_refill got req=%b err=%b exp req=1 err=0", fetch_req_o, err_o);
    end
    tick();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 1, 0, 0, 0);
    n_chk++;
    if (fetch_req_o !== 1'b0) begin
      n_err++; $display("FAIL collide_maxout got req=%b exp req=0", fetch_req_o);
    end
    tick();
  endtask

  task automatic test_refill_zero();
    do_reset();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 1, 0, 0, 0); tick();
    cyc(0, 0, 1, 0, 4);
    n_chk++;
    if (buf_wr_en_o !== 1'b1 || buf_wr_cnt_o !== 4'd0 || buf_rd_cnt_o !== 3'd0) begin
      n_err++; $display("FAIL refill_zero got wr=%b cnt=%0d rd=%0d exp wr=1 cnt=0 rd=0",
                        buf_wr_en_o, buf_wr_cnt_o, buf_rd_cnt_o);
    end
    tick();
    cyc(0, 0, 1, 3, 4);
    n_chk++;
    if (stall_o !== 1'b1 || buf_wr_en_o !== 1'b1 || buf_wr_cnt_o !== 4'd3 || buf_rd_cnt_o !== 3'd0) begin
      n_err++; $display("FAIL refill_three got st=%b wr=%b cnt=%0d rd=%0d exp st=1 wr=1 cnt=3 rd=0",
                        stall_o, buf_wr_en_o, buf_wr_cnt_o, buf_rd_cnt_o);
    end
    tick();
    cyc(0, 0, 0, 0, 4);
    n_chk++;
    if (buf_rd_cnt_o !== 3'd3 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL refill_run_pop got rd=%0d st=%b exp rd=3 st=0", buf_rd_cnt_o, stall_o);
    end
    tick();
  endtask

  task automatic test_rtn_err();
    do_reset();
    cyc(0, 0, 1, 5, 0);
    n_chk++;
    if (buf_wr_en_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL rtn_err_ignore got wr=%b err=%b exp wr=0 err=0", buf_wr_en_o, err_o);
    end
    tick();
    repeat (3) begin cyc(0, 0, 0, 0, 4); tick(); end
    cyc(0, 0, 0, 0, 4);
    n_chk++;
    if (err_o !== 1'b1 || occ_o !== 6'd0 || stall_o !== 1'b1) begin
      n_err++; $display("FAIL rtn_err_sticky got err=%b occ=%0d st=%b exp err=1 occ=0 st=1",
                        err_o, occ_o, stall_o);
    end
    tick();
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (err_o !== 1'b0) begin
      n_err++; $display("FAIL rtn_err_async_clear got err=%b exp err=0", err_o);
    end
    model_reset();
    @(posedge clock); #1 reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit fl, ack, rtn;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fl  = ($urandom_range(0, 24) == 0);
      ack = ($urandom_range(0, 3) != 0);
      rtn = (m_out > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 150) == 0);
      cyc(fl, ack, rtn, $urandom_range(0, 8), $urandom_range(0, 7));
      n_chk++;
      if (got_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_cycle c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_pop();
    test_flush_drain();
    test_flush_collide();
    test_refill_zero();
    test_rtn_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
